// File: rtl/cam2disp_linebuf_if.sv
// Camera-side pixel stream into the line buffer: line/frame levels plus pixel write strobe.
interface cam2disp_linebuf_if #(
  parameter int unsigned PIX_W = 24
);
  logic             csi_in_line;
  logic             csi_in_frame;
  logic [PIX_W-1:0] pix_in;
  logic             pix_wr;

  modport master (output csi_in_line, output csi_in_frame, output pix_in, output pix_wr);
  modport slave  (input  csi_in_line, input  csi_in_frame, input  pix_in, input  pix_wr);
endinterface

// File: rtl/cam2disp_linebuf.sv
// Camera-to-display line buffer: line counting/gating in csi_clk, async Gray-pointer FIFO
// into disp_clk, frame-gap flush and sticky overflow/underflow flags.
module cam2disp_linebuf #(
  parameter int unsigned PIX_W      = 24,
  parameter int unsigned AW         = 11,
  parameter int unsigned SKIP_LINES = 3,
  parameter int unsigned MAX_LINES  = 1300,
  parameter int unsigned LW         = 11
) (
  input  logic              csi_clk,
  input  logic              reset,
  input  logic              disp_clk,
  cam2disp_linebuf_if.slave csi,
  output logic              pix_valid,
  output logic [LW-1:0]     line_cnt,
  output logic [AW:0]       wr_level,
  output logic              ovf,
  input  logic              disp_frame,
  input  logic              disp_blank,
  output logic              disp_reset_n,
  output logic [PIX_W-1:0]  disp_pix,
  output logic              udf
);

  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(AW) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PIX_W-1:0] mem [DEPTH];

  // ---------------- csi_clk domain ----------------
  logic          line_d;
  logic          line_edge_c;
  logic          dfr_s1, dfr_s2;
  logic          flush_csi;
  logic [PW-1:0] wptr, wptr_gray;
  logic [PW-1:0] rsync_s1, rsync_s2;
  logic [PW-1:0] rsync_bin_c, level_c, wptr_nxt_c;
  logic          full_c, wr_en_c;

  assign line_edge_c = csi.csi_in_line & ~line_d;

  // Line counter with frame-low clear and saturation; gating outputs lag by one cycle
  always_ff @(posedge csi_clk) begin
    if (reset) begin
      line_d       <= 1'b0;
      line_cnt     <= '0;
      pix_valid    <= 1'b0;
      disp_reset_n <= 1'b0;
    end else begin
      line_d <= csi.csi_in_line;
      if (!csi.csi_in_frame)
        line_cnt <= '0;
      else if (line_edge_c && (line_cnt < LW'(MAX_LINES)))
        line_cnt <= line_cnt + LW'(1);
      pix_valid    <= (line_cnt >= LW'(SKIP_LINES));
      disp_reset_n <= (line_cnt >= LW'(1));
    end
  end

  assign rsync_bin_c = gray2bin(rsync_s2);
  assign level_c     = wptr - rsync_bin_c;
  assign full_c      = (level_c == PW'(DEPTH));
  assign wr_en_c     = csi.pix_wr & ~full_c & ~flush_csi;
  assign wptr_nxt_c  = flush_csi ? '0 : (wptr + PW'(wr_en_c));

  always_ff @(posedge csi_clk) begin
    if (reset) begin
      dfr_s1    <= 1'b0;
      dfr_s2    <= 1'b0;
      flush_csi <= 1'b0;
      rsync_s1  <= '0;
      rsync_s2  <= '0;
      wptr      <= '0;
      wptr_gray <= '0;
      wr_level  <= '0;
      ovf       <= 1'b0;
    end else begin
      dfr_s1    <= disp_frame;
      dfr_s2    <= dfr_s1;
      flush_csi <= ~csi.csi_in_frame & ~dfr_s2;
      rsync_s1  <= rptr_gray;
      rsync_s2  <= rsync_s1;
      wptr      <= wptr_nxt_c;
      wptr_gray <= bin2gray(wptr_nxt_c);
      // The synced read pointer lags the flush, so force the level to zero meanwhile
      wr_level  <= flush_csi ? '0 : (wptr_nxt_c - rsync_bin_c);
      if (csi.pix_wr && full_c && !flush_csi) ovf <= 1'b1;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (wr_en_c) mem[wptr[AW-1:0]] <= csi.pix_in;
  end

  // ---------------- disp_clk domain ----------------
  logic          drst_s1, drst;
  logic          flush_s1, flush_d;
  logic [PW-1:0] wsync_s1, wsync_s2;
  logic [PW-1:0] rptr, rptr_gray, rptr_nxt_c;
  logic          empty_c, rd_req_c, pop_c;

  always_ff @(posedge disp_clk) begin
    drst_s1 <= reset;
    drst    <= drst_s1;
  end

  assign rd_req_c   = ~disp_blank;
  assign empty_c    = (rptr_gray == wsync_s2);
  assign pop_c      = rd_req_c & ~empty_c & ~flush_d;
  assign rptr_nxt_c = flush_d ? '0 : (rptr + PW'(pop_c));

  always_ff @(posedge disp_clk) begin
    if (drst) begin
      flush_s1  <= 1'b0;
      flush_d   <= 1'b0;
      wsync_s1  <= '0;
      wsync_s2  <= '0;
      rptr      <= '0;
      rptr_gray <= '0;
      disp_pix  <= '0;
      udf       <= 1'b0;
    end else begin
      flush_s1  <= flush_csi;
      flush_d   <= flush_s1;
      wsync_s1  <= wptr_gray;
      wsync_s2  <= wsync_s1;
      rptr      <= rptr_nxt_c;
      rptr_gray <= bin2gray(rptr_nxt_c);
      if (pop_c) disp_pix <= mem[rptr[AW-1:0]];
      if (rd_req_c && empty_c && !flush_d) udf <= 1'b1;
    end
  end

endmodule

// File: doc/cam2disp_linebuf.md
CAM2DISP_LINEBUF -- requirements
Module: cam2disp_linebuf

Interface
REQ-001 SHALL have parameter PIX_W, default 24, pixel width in bits.
REQ-002 SHALL have parameter AW, default 11, FIFO address width; depth = 2**AW entries.
REQ-003 SHALL have parameter SKIP_LINES, default 3, number of camera lines suppressed before pix_valid asserts.
REQ-004 SHALL have parameter MAX_LINES, default 1300, saturation value of the line counter.
REQ-005 SHALL have parameter LW, default 11, line counter width.
REQ-006 SHALL have port csi_clk, input, 1, camera-domain clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset in the csi_clk domain.
REQ-008 SHALL have port disp_clk, input, 1, display-domain clock, asynchronous to csi_clk.
REQ-009 SHALL have port csi_in_line, input, 1, camera line-active level.
REQ-010 SHALL have port csi_in_frame, input, 1, camera frame-active level.
REQ-011 SHALL have port pix_in, input, PIX_W, camera pixel.
REQ-012 SHALL have port pix_wr, input, 1, write strobe for pix_in.
REQ-013 SHALL have port pix_valid, output, 1, camera-side enable for debayer output.
REQ-014 SHALL have port line_cnt, output, LW, current camera line count.
REQ-015 SHALL have port wr_level, output, AW+1, FIFO fill level as seen by the csi_clk side.
REQ-016 SHALL have port ovf, output, 1, sticky overflow flag in the csi_clk domain.
REQ-017 SHALL have port disp_frame, input, 1, display frame-active level.
REQ-018 SHALL have port disp_blank, input, 1, display blanking; read request = ~disp_blank.
REQ-019 SHALL have port disp_reset_n, output, 1, display timing-generator release, csi_clk domain.
REQ-020 SHALL have port disp_pix, output, PIX_W, registered display pixel.
REQ-021 SHALL have port udf, output, 1, sticky underflow flag in the disp_clk domain.

Function
REQ-022 SHALL detect the csi_in_line rising edge with a 1-cycle delay register; each edge while csi_in_frame=1 increments line_cnt, which saturates at MAX_LINES.
REQ-023 SHALL clear line_cnt on every cycle with csi_in_frame=0; the clear has priority over an edge in the same cycle.
REQ-024 SHALL register pix_valid = (line_cnt >= SKIP_LINES) and disp_reset_n = (line_cnt >= 1), giving 1 cycle of latency from line_cnt.
REQ-025 SHALL implement an async FIFO with binary-to-Gray pointers of width AW+1 and 2-flop synchronisers in each direction.
REQ-026 SHALL write on pix_wr=1 when not full; pix_wr=1 while full drops the pixel and sets ovf.
REQ-027 SHALL pop on ~disp_blank when not empty and register the entry into disp_pix one disp_clk later.
REQ-028 SHALL treat ~disp_blank while empty as an underflow: disp_pix holds its previous value and udf sets.
REQ-029 SHALL make a written entry readable (empty=0) no later than 3 disp_clk after the write edge.
REQ-030 SHALL compute flush = ~csi_in_frame & ~disp_frame_s in csi_clk, where disp_frame_s is disp_frame passed through a 2-flop synchroniser.
REQ-031 SHALL pass flush through a 2-flop synchroniser into disp_clk.
REQ-032 SHALL hold each pointer at 0 while that side's copy of flush=1; writes are ignored during flush.
REQ-033 SHALL set wr_level = wptr - synced rptr modulo 2**(AW+1); full when wr_level = 2**AW.
REQ-034 SHALL keep ovf and udf set until reset.
REQ-035 SHALL give simultaneous full+write with a read in the same period no special case: the write is dropped only if full is seen in csi_clk.

Reset
REQ-036 SHALL, on reset, set line_cnt=0, pix_valid=0, disp_reset_n=0, wr_level=0, ovf=0, wptr=0, and delay-reg=0 on the same csi_clk edge.
REQ-037 SHALL derive the disp_clk-side reset from reset through a 2-flop synchroniser; it clears rptr=0, disp_pix=0, udf=0.
REQ-038 SHALL allow reset mid-frame; the FIFO returns empty and line counting restarts at the next csi_in_frame=1.

Verification
REQ-039 SHALL be verified by: frame high, 4 line edges -> line_cnt=4; pix_valid=1 from the cycle after line_cnt=3; disp_reset_n=1 after line_cnt=1.
REQ-040 SHALL be verified by: 1400 line edges -> line_cnt saturates at 1300; frame low -> 0 on the next edge.
REQ-041 SHALL be verified by: write 0x000001..0x000010 with disp_blank=0 -> disp_pix shows the same sequence in order, no ovf/udf.
REQ-042 SHALL be verified by: 2049 writes with disp_blank=1 (AW=11) -> wr_level=2048, last pixel dropped, ovf=1.
REQ-043 SHALL be verified by: disp_blank=0 with the FIFO empty -> udf=1, disp_pix unchanged.
REQ-044 SHALL be verified by: both frames low for 10 cycles -> wr_level=0 and the next read returns the first post-flush pixel.
